// File: rtl/mdu_ctrl_pkg.sv
// Shared MDU definitions: md_op encodings, default latencies, FSM states.
// Imported by decode, hazard and the execute-stage MDU controller.
package mdu_ctrl_pkg;

    typedef logic [2:0] md_op_t;

    localparam md_op_t MD_NONE  = 3'd0;
    localparam md_op_t MD_MULT  = 3'd1;
    localparam md_op_t MD_MULTU = 3'd2;
    localparam md_op_t MD_DIV   = 3'd3;
    localparam md_op_t MD_DIVU  = 3'd4;
    localparam md_op_t MD_MTHI  = 3'd5;
    localparam md_op_t MD_MTLO  = 3'd6;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        IDLE,
        RUN
    } mdu_state_e;

    function automatic logic is_multi(md_op_t op);
        return (op == MD_MULT) || (op == MD_MULTU) ||
               (op == MD_DIV)  || (op == MD_DIVU);
    endfunction

    function automatic logic is_div(md_op_t op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> MDU bundle: request, operands, D-stage hint and HI/LO/status.
// master = execute/hazard side, slave = the MDU controller.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic        start;
    md_op_t      md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        D_md;
    logic        busy;
    logic        stall_req;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, md_op, rs_val, rt_val, D_md,
        input  busy, stall_req, done, hi, lo
    );

    modport slave (
        input  start, md_op, rs_val, rt_val, D_md,
        output busy, stall_req, done, hi, lo
    );

endinterface

// File: rtl/mdu_ctrl.sv
// Multi-cycle mult/div controller with architectural HI/LO.
// Result is formed from latched operands and committed after N busy cycles.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

    mdu_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    md_op_t      op_q, op_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        done_q, done_d;

    logic signed [63:0] a64;
    logic signed [63:0] b64;
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    logic [63:0]        res;

    // Arithmetic only ever sees the latched operands.
    always_comb begin
        a64 = {{32{a_q[31]}}, a_q};
        b64 = {{32{b_q[31]}}, b_q};
        sa  = a_q;
        sb  = b_q;
        res = 64'd0;
        case (op_q)
            MD_MULT:  res = a64 * b64;
            MD_MULTU: res = {32'd0, a_q} * {32'd0, b_q};
            MD_DIV:   res = {32'(sa % sb), 32'(sa / sb)};
            MD_DIVU:  res = {a_q % b_q, a_q / b_q};
            default:  res = 64'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start && is_multi(bus.md_op)) begin
                    state_d = RUN;
                    cnt_d   = is_div(bus.md_op) ? DIV_N : MULT_N;
                    a_d     = bus.rs_val;
                    b_d     = bus.rt_val;
                    op_d    = bus.md_op;
                end else if (bus.start && bus.md_op == MD_MTHI) begin
                    hi_d = bus.rs_val;
                end else if (bus.start && bus.md_op == MD_MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            RUN: begin
                if (cnt_q <= 4'd1) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    done_d  = 1'b1;
                    // Divide by zero keeps HI/LO but still spends the full latency.
                    if (!(is_div(op_q) && b_q == 32'd0)) begin
                        hi_d = res[63:32];
                        lo_d = res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= MD_NONE;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy      = (state_q == RUN);
    assign bus.done      = done_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.stall_req = bus.D_md &
        ((state_q == RUN) | (bus.start & is_multi(bus.md_op)));

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL have parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port start, input, 1: one-cycle request from E stage; qualifies md_op.
REQ-006 SHALL have port md_op, input, 3: operation code from the shared package.
REQ-007 SHALL have port rs_val, input, 32: forwarded rs operand in E.
REQ-008 SHALL have port rt_val, input, 32: forwarded rt operand in E.
REQ-009 SHALL have port D_md, input, 1: the D-stage instruction uses the MDU (mult/multu/div/divu/mfhi/mflo/mthi/mtlo).
REQ-010 SHALL have port busy, output, 1: an operation is in progress.
REQ-011 SHALL have port stall_req, output, 1: stall request to the hazard unit.
REQ-012 SHALL have port done, output, 1: one-cycle pulse on the cycle after HI/LO commit.
REQ-013 SHALL have port hi, output, 32: architectural HI register.
REQ-014 SHALL have port lo, output, 32: architectural LO register.

Function
REQ-015 SHALL implement states IDLE, RUN.
- IDLE -> RUN: start with op in {MULT, MULTU, DIV, DIVU}.
- RUN -> IDLE: after the final busy cycle.
REQ-016 SHALL capture rs_val and rt_val at the start edge, and SHALL compute the pending 64-bit result from the captured values only.
REQ-017 SHALL, for start at cycle t:
- drive busy=1 for cycles t+1 .. t+N, where N = MULT_CYCLES or DIV_CYCLES;
- load HI/LO on the edge ending cycle t+N;
- drive busy=0 and done=1 in cycle t+N+1.
REQ-018 SHALL compute mult as the signed 64-bit product and multu as the unsigned product, with {hi,lo} = product.
REQ-019 SHALL compute div/divu as lo = quotient (truncated toward zero) and hi = remainder (sign of dividend for div).
REQ-020 SHALL leave HI and LO unchanged when the divisor is 0, while still running the full DIV_CYCLES busy period.
REQ-021 SHALL, for MTHI/MTLO with start in IDLE, write rs_val to hi/lo on the same edge with no busy period and no done pulse.
REQ-022 SHALL ignore start of any op while busy=1: no state, HI/LO or counter change.
REQ-023 SHALL ignore start with MD_NONE and with undefined codes.
REQ-024 SHALL drive stall_req = D_md & (busy | (start & op is a multi-cycle op)), purely combinational.
REQ-025 SHALL keep the down-counter at 4 bits; the counter SHALL NOT wrap, and N=1 SHALL be legal.
REQ-026 SHALL update hi/lo only at commit or MTHI/MTLO; they SHALL be stable at all other times.

Reset
REQ-027 SHALL, on reset low (asynchronous, any cycle including mid-RUN):
- go to IDLE;
- clear busy, done, the counter, the operand latches, hi and lo to 0;
- abandon any pending result.
REQ-028 SHALL accept start on the first rising edge after reset deasserts.

Structure
REQ-029 SHALL place the md_op encodings (MD_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6) and the default latency constants in the shared macros package used by decode and hazard logic.
REQ-030 SHALL be a single module; the arithmetic SHALL stay inline with no sub-module.
REQ-031 SHALL be instantiated inside the execute stage, replacing the existing start/Busy logic; hazard SHALL consume stall_req.

Verification
REQ-032 SHALL cover: mult rs=0xFFFFFFFD, rt=5 -> busy for cycles t+1..t+5, then hi=0xFFFFFFFF, lo=0xFFFFFFF1, done=1 at t+6.
REQ-033 SHALL cover: divu 7,2 -> lo=3, hi=1 after 10 busy cycles; div 0xFFFFFFF9,2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 SHALL cover: div 5,0 with hi/lo preset 0x11/0x22 -> 10 busy cycles, hi=0x11, lo=0x22 unchanged.
REQ-035 SHALL cover: mthi 0xABCD at t -> hi=0xABCD at t+1, busy=0 throughout; a second mult start during busy -> ignored, result from the first op.
REQ-036 SHALL cover: D_md=1 with start of multu, then D_md held through busy -> stall_req=1 in cycles t..t+5 and 0 at t+6; D_md=0 -> stall_req=0 throughout.
REQ-037 SHALL cover: reset pulsed low at cycle t+3 of a div -> busy=0, hi=lo=0 immediately, no done pulse, next start accepted normally.
